// File: rtl/lsu_pkg.sv
// Shared LSU definitions: mapped-region bounds, control encoding, request bundle.
// Used by the arbiter and by any bus master that needs the same address decode.
package lsu_pkg;

  localparam logic [15:0] DMEM_BASE    = 16'h2000;
  localparam logic [15:0] DMEM_LIMIT   = 16'h3FFF;
  localparam logic [15:0] OUTBUF_BASE  = 16'h7000;
  localparam logic [15:0] OUTBUF_LIMIT = 16'h703F;
  localparam logic [15:0] INBUF_BASE   = 16'h7800;
  localparam logic [15:0] INBUF_LIMIT  = 16'h781F;

  // Size/sign encoding carried to the LSU untouched; codes 3, 6, 7 are unused.
  typedef enum logic [2:0] {
    CTRL_LB  = 3'b000,
    CTRL_LH  = 3'b001,
    CTRL_LW  = 3'b010,
    CTRL_LBU = 3'b100,
    CTRL_LHU = 3'b101
  } lsu_ctrl_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    lsu_ctrl_e   ctrl;
  } lsu_req_t;

  function automatic logic in_region(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input logic [15:0] limit);
    return (addr >= base) && (addr <= limit);
  endfunction

endpackage

// File: rtl/lsu_addr_decode.sv
// Combinational legality check of a 16-bit LSU address for a load or store.
module lsu_addr_decode
  import lsu_pkg::*;
(
  input  logic [15:0] addr,
  input  logic        we,
  output logic        legal
);

  // The input buffer is read-only, so a store there is illegal.
  assign legal = in_region(addr, DMEM_BASE, DMEM_LIMIT)
              || in_region(addr, OUTBUF_BASE, OUTBUF_LIMIT)
              || (in_region(addr, INBUF_BASE, INBUF_LIMIT) && !we);

endmodule

// File: rtl/lsu_arbiter.sv
// Shares the LSU port between the core path (M0) and the DMA/debug loader (M1),
// with M1 starvation override, address filtering and a one-cycle response register.
module lsu_arbiter
  import lsu_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_req,
  input  logic        i_m1_req,
  input  logic        i_m0_we,
  input  logic        i_m1_we,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [31:0] i_m1_wdata,
  input  logic [2:0]  i_m0_ctrl,
  input  logic [2:0]  i_m1_ctrl,
  output logic        o_m0_gnt,
  output logic        o_m1_gnt,
  output logic        o_m0_rsp_valid,
  output logic        o_m1_rsp_valid,
  output logic [31:0] o_m0_rdata,
  output logic [31:0] o_m1_rdata,
  output logic        o_m0_err,
  output logic        o_m1_err,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_st_data,
  output logic        o_lsu_wren,
  output logic        o_lsu_rden,
  output logic [2:0]  o_control,
  input  logic [31:0] i_ld_data
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]  starve_cnt;
  logic        m1_wins;
  logic        any_gnt;
  logic        legal;
  logic        issue;
  lsu_req_t    m0_r;
  lsu_req_t    m1_r;
  lsu_req_t    win;

  logic        rsp_valid_q;
  logic        rsp_m1_q;
  logic        rsp_err_q;
  logic [31:0] rsp_data_q;

  always_comb begin
    m0_r = '{we: i_m0_we, addr: i_m0_addr, wdata: i_m0_wdata, ctrl: lsu_ctrl_e'(i_m0_ctrl)};
    m1_r = '{we: i_m1_we, addr: i_m1_addr, wdata: i_m1_wdata, ctrl: lsu_ctrl_e'(i_m1_ctrl)};
  end

  assign m1_wins  = i_m1_req && (!i_m0_req || (starve_cnt == LIMIT));
  assign o_m1_gnt = !i_rst && m1_wins;
  assign o_m0_gnt = !i_rst && i_m0_req && !m1_wins;
  assign any_gnt  = o_m0_gnt || o_m1_gnt;
  assign win      = m1_wins ? m1_r : m0_r;

  lsu_addr_decode u_decode (
    .addr  (win.addr[15:0]),
    .we    (win.we),
    .legal (legal)
  );

  // Illegal accesses are granted but never reach the LSU.
  assign issue      = any_gnt && legal;
  assign o_lsu_addr = issue ? win.addr  : '0;
  assign o_st_data  = issue ? win.wdata : '0;
  assign o_control  = issue ? win.ctrl  : 3'b000;
  assign o_lsu_wren = issue && win.we;
  assign o_lsu_rden = issue && !win.we;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_cnt <= '0;
    end else if (!i_m1_req || o_m1_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_valid_q <= 1'b0;
      rsp_m1_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= any_gnt;
      rsp_m1_q    <= o_m1_gnt;
      rsp_err_q   <= any_gnt && !legal;
      rsp_data_q  <= (issue && !win.we) ? i_ld_data : '0;
    end
  end

  // Gating with i_rst drops a response that is on the outputs when reset arrives.
  assign o_m0_rsp_valid = rsp_valid_q && !rsp_m1_q && !i_rst;
  assign o_m1_rsp_valid = rsp_valid_q &&  rsp_m1_q && !i_rst;
  assign o_m0_err       = o_m0_rsp_valid && rsp_err_q;
  assign o_m1_err       = o_m1_rsp_valid && rsp_err_q;
  assign o_m0_rdata     = o_m0_rsp_valid ? rsp_data_q : '0;
  assign o_m1_rdata     = o_m1_rsp_valid ? rsp_data_q : '0;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed and randomized checks of lsu_arbiter against a cycle-level reference
// model built from the region map and arbitration rules.
module tb_lsu_arbiter;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [2:0]  m0_ctrl, m1_ctrl;
  logic [31:0] ld_data;
  logic        m0_gnt, m1_gnt, m0_rv, m1_rv, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata, lsu_addr, st_data;
  logic        lsu_wren, lsu_rden;
  logic [2:0]  control;

  int total = 0;
  int passed = 0;
  int failed = 0;

  // reference model state
  int          wait_n = 0;
  bit          rv = 0, rid = 0, rerr = 0;
  logic [31:0] rdat = '0;
  bit          last_g0 = 0, last_g1 = 0;

  lsu_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req), .i_m1_req(m1_req), .i_m0_we(m0_we), .i_m1_we(m1_we),
    .i_m0_addr(m0_addr), .i_m1_addr(m1_addr), .i_m0_wdata(m0_wdata), .i_m1_wdata(m1_wdata),
    .i_m0_ctrl(m0_ctrl), .i_m1_ctrl(m1_ctrl),
    .o_m0_gnt(m0_gnt), .o_m1_gnt(m1_gnt), .o_m0_rsp_valid(m0_rv), .o_m1_rsp_valid(m1_rv),
    .o_m0_rdata(m0_rdata), .o_m1_rdata(m1_rdata), .o_m0_err(m0_err), .o_m1_err(m1_err),
    .o_lsu_addr(lsu_addr), .o_st_data(st_data), .o_lsu_wren(lsu_wren), .o_lsu_rden(lsu_rden),
    .o_control(control), .i_ld_data(ld_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit mapped(input logic [31:0] a, input bit we);
    int lo [3] = '{'h2000, 'h7000, 'h7800};
    int sz [3] = '{'h2000, 'h40, 'h20};
    bit wr [3] = '{1, 1, 0};
    int off = int'(a[15:0]);
    for (int r = 0; r < 3; r++)
      if (off >= lo[r] && off < lo[r] + sz[r]) return wr[r] || !we;
    return 0;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] hi;
    logic [15:0] edges [6] = '{16'h1FFF, 16'h4000, 16'h6FFF, 16'h7040, 16'h77FF, 16'h7820};
    hi = $urandom() & 32'hFFFF_0000;
    case ($urandom_range(0, 5))
      0, 1:    return hi | (32'h2000 + $urandom_range(0, 'h1FFF));
      2:       return hi | (32'h7000 + $urandom_range(0, 'h3F));
      3:       return hi | (32'h7800 + $urandom_range(0, 'h1F));
      4:       return hi | {16'h0, edges[$urandom_range(0, 5)]};
      default: return $urandom();
    endcase
  endfunction

  task automatic settle();
    @(negedge clk);
  endtask

  // Called at the negedge: checks this cycle's outputs, then advances the model past the edge.
  task automatic cycle();
    bit e0 = 0, e1 = 0, lg, w_we;
    logic [31:0] w_addr, w_wdata;
    logic [2:0]  w_ctrl;
    bit n_rv, n_rid, n_rerr;
    logic [31:0] n_rdat;
    int n_wait;
    if (!rst) begin
      if (m1_req && (!m0_req || wait_n == LIMIT)) e1 = 1;
      else if (m0_req) e0 = 1;
    end
    w_we    = e1 ? m1_we : m0_we;
    w_addr  = e1 ? m1_addr : m0_addr;
    w_wdata = e1 ? m1_wdata : m0_wdata;
    w_ctrl  = e1 ? m1_ctrl : m0_ctrl;
    lg = mapped(w_addr, w_we);
    chk("m0_gnt", m0_gnt, e0);
    chk("m1_gnt", m1_gnt, e1);
    chk("lsu_wren", lsu_wren, (e0 || e1) && lg && w_we);
    chk("lsu_rden", lsu_rden, (e0 || e1) && lg && !w_we);
    if (!(e0 || e1)) begin
      chk("idle_addr", lsu_addr, 0);
      chk("idle_st_data", st_data, 0);
      chk("idle_control", control, 0);
    end else if (lg) begin
      chk("lsu_addr", lsu_addr, w_addr);
      chk("st_data", st_data, w_wdata);
      chk("control", control, w_ctrl);
    end
    chk("m0_rsp_valid", m0_rv, rv && !rid && !rst);
    chk("m1_rsp_valid", m1_rv, rv && rid && !rst);
    chk("m0_err", m0_err, (rv && !rid && !rst) ? rerr : 0);
    chk("m1_err", m1_err, (rv && rid && !rst) ? rerr : 0);
    chk("m0_rdata", m0_rdata, (rv && !rid && !rst) ? rdat : 0);
    chk("m1_rdata", m1_rdata, (rv && rid && !rst) ? rdat : 0);
    if (rst) begin
      n_rv = 0; n_rid = 0; n_rerr = 0; n_rdat = 0; n_wait = 0;
    end else begin
      n_rv   = e0 || e1;
      n_rid  = e1;
      n_rerr = (e0 || e1) && !lg;
      n_rdat = ((e0 || e1) && lg && !w_we) ? ld_data : 0;
      n_wait = (!m1_req || e1) ? 0 : (wait_n < LIMIT ? wait_n + 1 : wait_n);
    end
    @(posedge clk);
    rv = n_rv; rid = n_rid; rerr = n_rerr; rdat = n_rdat; wait_n = n_wait;
    last_g0 = e0; last_g1 = e1;
    #1;
  endtask

  initial begin
    rst = 1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h2000; m0_wdata = 32'h0; m0_ctrl = 3'b010;
    m1_req = 1; m1_we = 0; m1_addr = 32'h2010; m1_wdata = 32'h0; m1_ctrl = 3'b010;
    ld_data = 32'h1234_5678;

    repeat (2) begin
      settle();
      chk("rst_m0_gnt", m0_gnt, 0);
      chk("rst_m1_gnt", m1_gnt, 0);
      chk("rst_rden", lsu_rden, 0);
      chk("rst_addr", lsu_addr, 0);
      cycle();
    end
    rst = 0;
    settle();
    chk("release_m0_gnt", m0_gnt, 1);
    chk("release_m1_gnt", m1_gnt, 0);
    cycle();

    m1_req = 0;
    m0_addr = 32'h2004; ld_data = 32'hDEAD_BEEF;
    settle();
    chk("m0_load_gnt", m0_gnt, 1);
    chk("m0_load_rden", lsu_rden, 1);
    chk("m0_load_addr", lsu_addr, 32'h2004);
    cycle();
    m0_req = 0; ld_data = 32'h0;
    settle();
    chk("m0_load_rsp_valid", m0_rv, 1);
    chk("m0_load_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("m0_load_err", m0_err, 0);
    cycle();

    m0_req = 1; m0_we = 0; m0_addr = 32'h2008;
    m1_req = 1; m1_we = 1; m1_addr = 32'h7000; m1_wdata = 32'hA5A5_5A5A;
    for (int k = 0; k < LIMIT; k++) begin
      settle();
      chk("starve_wait_m1_gnt", m1_gnt, 0);
      cycle();
    end
    settle();
    chk("starve_m1_gnt", m1_gnt, 1);
    chk("starve_m1_wren", lsu_wren, 1);
    chk("starve_m1_data", st_data, 32'hA5A5_5A5A);
    cycle();
    m1_req = 0;
    settle();
    chk("starve_m0_resume", m0_gnt, 1);
    chk("starve_cnt_clear", dut.starve_cnt, 0);
    cycle();

    m0_req = 0;
    m1_req = 1; m1_we = 1; m1_addr = 32'h7804;
    settle();
    chk("ill_store_gnt", m1_gnt, 1);
    chk("ill_store_wren", lsu_wren, 0);
    chk("ill_store_rden", lsu_rden, 0);
    cycle();
    m1_req = 0;
    settle();
    chk("ill_store_rsp", m1_rv, 1);
    chk("ill_store_err", m1_err, 1);
    chk("ill_store_rdata", m1_rdata, 0);
    cycle();

    m0_req = 1; m0_we = 0; m0_addr = 32'h5000; ld_data = 32'hCAFE_F00D;
    settle();
    chk("unmapped_gnt", m0_gnt, 1);
    chk("unmapped_rden", lsu_rden, 0);
    cycle();
    m0_req = 0;
    settle();
    chk("unmapped_err", m0_err, 1);
    chk("unmapped_rdata", m0_rdata, 0);
    cycle();

    m1_req = 1; m1_we = 0; m1_addr = 32'h2100; ld_data = 32'h0BAD_CAFE;
    settle();
    chk("midrst_gnt", m1_gnt, 1);
    cycle();
    rst = 1; m1_req = 0;
    settle();
    chk("midrst_rsp_valid", m1_rv, 0);
    chk("midrst_starve_cnt", dut.starve_cnt, 0);
    cycle();
    rst = 0;
    settle();
    chk("postrst_rsp_valid", m1_rv, 0);
    cycle();

    // Randomized traffic: requests hold their payload until granted.
    for (int c = 0; c < 600; c++) begin
      if (!m0_req || last_g0) begin
        m0_req = ($urandom_range(0, 7) != 0);
        m0_we = $urandom_range(0, 1); m0_addr = rand_addr();
        m0_wdata = $urandom(); m0_ctrl = 3'($urandom_range(0, 7));
      end
      if (!m1_req || last_g1) begin
        m1_req = ($urandom_range(0, 1) != 0);
        m1_we = $urandom_range(0, 1); m1_addr = rand_addr();
        m1_wdata = $urandom(); m1_ctrl = 3'($urandom_range(0, 7));
      end
      rst = ($urandom_range(0, 63) == 0);
      ld_data = $urandom();
      settle();
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
